// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite response codes and bus widths
package axi_lite_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

endpackage

// File: rtl/sp_ram_be.sv
// rtl/sp_ram_be.sv - synchronous RAM with byte write enables, read-first, separate ports
module sp_ram_be
    import axi_lite_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-masked write; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
                if (wstrb[k]) begin
                    mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Registered read port: samples pre-write contents, holds until the next read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_lite_ram.sv
// rtl/axi_lite_ram.sv - AXI4-Lite slave wrapping a 1024x32 byte-writable RAM
module axi_lite_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);
    import axi_lite_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_HAVE_AW = 2'd1;
    localparam logic [1:0] W_HAVE_W  = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_RESP = 1'b1;

    logic [1:0]              wstate;
    logic                    rstate;
    logic [IDX_W-1:0]        waddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;

    logic aw_hs, w_hs, ar_hs;
    logic ram_we, ram_re;
    logic unused_bits;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // W_RESP with bvalid low means both halves are held and the commit happens this edge.
    // Gating with aresetn drops a commit that coincides with reset.
    assign ram_we = aresetn && (wstate == W_RESP) && !s_axi_bvalid;
    assign ram_re = aresetn && ar_hs;

    assign s_axi_bresp = OKAY;
    assign s_axi_rresp = OKAY;

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Write path: collect AW and W in any order, commit, then hold B until accepted.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wstate        <= W_IDLE;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            s_axi_bvalid  <= 1'b0;
        end else begin
            if (aw_hs) begin
                waddr_q       <= s_axi_awaddr[ADDR_WIDTH-1:2];
                s_axi_awready <= 1'b0;
            end
            if (w_hs) begin
                wdata_q      <= s_axi_wdata;
                wstrb_q      <= s_axi_wstrb;
                s_axi_wready <= 1'b0;
            end
            case (wstate)
                W_IDLE: begin
                    if (aw_hs && w_hs) wstate <= W_RESP;
                    else if (aw_hs)    wstate <= W_HAVE_AW;
                    else if (w_hs)     wstate <= W_HAVE_W;
                end
                W_HAVE_AW: if (w_hs)  wstate <= W_RESP;
                W_HAVE_W:  if (aw_hs) wstate <= W_RESP;
                default: begin
                    if (!s_axi_bvalid) begin
                        s_axi_bvalid <= 1'b1;
                    end else if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        wstate        <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Read path: one outstanding read; arready stays low while R is pending.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rstate        <= R_IDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        rstate        <= R_RESP;
                    end
                end
                default: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rstate        <= R_IDLE;
                    end
                end
            endcase
        end
    end

    sp_ram_be #(
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_ram (
        .clk    (aclk),
        .resetn (aresetn),
        .we     (ram_we),
        .waddr  (waddr_q),
        .wdata  (wdata_q),
        .wstrb  (wstrb_q),
        .re     (ram_re),
        .raddr  (s_axi_araddr[ADDR_WIDTH-1:2]),
        .rdata  (s_axi_rdata)
    );

endmodule

// File: tb/tb_axi_lite_ram.sv
// tb/tb_axi_lite_ram.sv - directed self-checking bench for axi_lite_ram
module tb_axi_lite_ram;

    logic        aclk;
    logic        aresetn;
    logic [11:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int tests = 0;
    int fails = 0;

    axi_lite_ram dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // AW and W presented together; returns BRESP and a timeout flag.
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output bit to);
        int  n;
        bit  aw_hs, w_hs, b_hs;
        to = 0;
        resp = 2'bxx;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 100) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        if (n >= 100) to = 1;
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        n = 0;
        b_hs = 0;
        while (!b_hs && n < 100) begin
            b_hs = bvalid;
            resp = bresp;
            tick();
            n++;
        end
        if (!b_hs) to = 1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output bit to);
        int n;
        bit ar_hs, r_hs;
        to = 0;
        d = 'x;
        resp = 2'bxx;
        araddr = a;
        arvalid = 1'b1;
        n = 0;
        ar_hs = 0;
        while (!ar_hs && n < 100) begin
            ar_hs = arready;
            tick();
            n++;
        end
        if (!ar_hs) to = 1;
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0;
        r_hs = 0;
        while (!r_hs && n < 100) begin
            r_hs = rvalid;
            d = rdata;
            resp = rresp;
            tick();
            n++;
        end
        if (!r_hs) to = 1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick(); tick(); tick();
        tests++;
        if ({awready, wready, arready} !== 3'b111) begin
            fails++;
            $display("FAIL reset_ready: got %b want 111", {awready, wready, arready});
        end
        tests++;
        if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
            fails++;
            $display("FAIL reset_valid_resp: got %b want 000000", {bvalid, rvalid, bresp, rresp});
        end
        tests++;
        if (rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdata: got %h want 00000000", rdata);
        end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_fill_readback();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          to;
        for (int i = 0; i < 1024; i++) begin
            axi_write(12'(4 * i), 32'(i), 4'hF, resp, to);
            tests++;
            if (to !== 1'b0 || resp !== 2'b00) begin
                fails++;
                $display("FAIL fill_write[%0d]: got resp=%b timeout=%0d want resp=00 timeout=0", i, resp, to);
            end
        end
        for (int i = 0; i < 1024; i++) begin
            axi_read(12'(4 * i), d, resp, to);
            tests++;
            if (to !== 1'b0 || resp !== 2'b00 || d !== 32'(i)) begin
                fails++;
                $display("FAIL fill_read[%0d]: got data=%h resp=%b timeout=%0d want data=%h resp=00",
                         i, d, resp, to, 32'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        araddr = 12'h004;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        tests++;
        if (rvalid !== 1'b1 || rdata !== 32'h1 || arready !== 1'b0) begin
            fails++;
            $display("FAIL bp_latency: got rvalid=%b rdata=%h arready=%b want 1 00000001 0", rvalid, rdata, arready);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++;
            if (rvalid !== 1'b1 || rdata !== 32'h1 || arready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got rvalid=%b rdata=%h arready=%b want 1 00000001 0",
                         c, rvalid, rdata, arready);
            end
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        tests++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got rvalid=%b arready=%b want 0 1", rvalid, arready);
        end
    endtask

    task automatic test_unaligned();
        logic [31:0] d;
        logic [1:0]  resp;
        bit          to;
        axi_read(12'h006, d, resp, to);
        tests++;
        if (to !== 1'b0 || d !== 32'h1) begin
            fails++;
            $display("FAIL unaligned_read: got %h timeout=%0d want 00000001", d, to);
        end
    endtask

    task automatic test_byte_strobes();
        logic [31:0] d;
        logic [1:0]  resp;
        bit          to;
        axi_write(12'h010, 32'hAABBCCDD, 4'hF, resp, to);
        axi_write(12'h010, 32'h11223344, 4'b0101, resp, to);
        axi_read(12'h010, d, resp, to);
        tests++;
        if (to !== 1'b0 || d !== 32'hAA22CC44) begin
            fails++;
            $display("FAIL byte_strobes: got %h timeout=%0d want aa22cc44", d, to);
        end
    endtask

    task automatic test_channel_order();
        logic [31:0] d;
        logic [1:0]  resp;
        bit          to;
        // W three cycles ahead of AW
        wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tests++;
        if (wready !== 1'b0 || awready !== 1'b1) begin
            fails++;
            $display("FAIL wfirst_ready: got wready=%b awready=%b want 0 1", wready, awready);
        end
        tick(); tick();
        tests++;
        if (bvalid !== 1'b0 || wready !== 1'b0) begin
            fails++;
            $display("FAIL wfirst_wait: got bvalid=%b wready=%b want 0 0", bvalid, wready);
        end
        awaddr = 12'h020; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tests++;
        if (bvalid !== 1'b0 || awready !== 1'b0) begin
            fails++;
            $display("FAIL wfirst_aw: got bvalid=%b awready=%b want 0 0", bvalid, awready);
        end
        tick();
        tests++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            fails++;
            $display("FAIL wfirst_commit: got bvalid=%b bresp=%b want 1 00", bvalid, bresp);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        tests++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            fails++;
            $display("FAIL wfirst_bdone: got %b want 011", {bvalid, awready, wready});
        end
        axi_read(12'h020, d, resp, to);
        tests++;
        if (to !== 1'b0 || d !== 32'h5A5A5A5A) begin
            fails++;
            $display("FAIL wfirst_read: got %h want 5a5a5a5a", d);
        end
        // AW ahead of W
        awaddr = 12'h020; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tests++;
        if (awready !== 1'b0 || wready !== 1'b1) begin
            fails++;
            $display("FAIL awfirst_ready: got awready=%b wready=%b want 0 1", awready, wready);
        end
        tick(); tick();
        wdata = 32'hC3C30F0F; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tests++;
        if (bvalid !== 1'b0) begin
            fails++;
            $display("FAIL awfirst_w: got bvalid=%b want 0", bvalid);
        end
        tick();
        tests++;
        if (bvalid !== 1'b1) begin
            fails++;
            $display("FAIL awfirst_commit: got bvalid=%b want 1", bvalid);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(12'h020, d, resp, to);
        tests++;
        if (to !== 1'b0 || d !== 32'hC3C30F0F) begin
            fails++;
            $display("FAIL awfirst_read: got %h want c3c30f0f", d);
        end
    endtask

    task automatic test_read_first();
        logic [31:0] d;
        logic [1:0]  resp;
        bit          to;
        axi_write(12'h040, 32'h01010101, 4'hF, resp, to);
        awaddr = 12'h040; wdata = 32'h02020202; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 12'h040; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tests++;
        if (rvalid !== 1'b1 || rdata !== 32'h01010101 || bvalid !== 1'b1) begin
            fails++;
            $display("FAIL read_first: got rvalid=%b rdata=%h bvalid=%b want 1 01010101 1", rvalid, rdata, bvalid);
        end
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        axi_read(12'h040, d, resp, to);
        tests++;
        if (to !== 1'b0 || d !== 32'h02020202) begin
            fails++;
            $display("FAIL read_after_write: got %h want 02020202", d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        logic [1:0]  resp;
        bit          to;
        axi_write(12'h050, 32'hDEADBEEF, 4'hF, resp, to);
        // AW accepted, reset before W
        awaddr = 12'h050; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tests++;
        if (awready !== 1'b0) begin
            fails++;
            $display("FAIL rst_aw_captured: got awready=%b want 0", awready);
        end
        aresetn = 1'b0;
        tick(); tick();
        aresetn = 1'b1;
        tests++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            fails++;
            $display("FAIL rst_mid_state: got %b want 11100", {awready, wready, arready, bvalid, rvalid});
        end
        tick();
        // both halves held, reset lands on the commit edge
        awaddr = 12'h050; wdata = 32'h99999999; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        aresetn = 1'b0;
        tick();
        tests++;
        if (bvalid !== 1'b0 || {awready, wready} !== 2'b11) begin
            fails++;
            $display("FAIL rst_commit_drop: got bvalid=%b ready=%b want 0 11", bvalid, {awready, wready});
        end
        tick();
        aresetn = 1'b1;
        tick();
        axi_read(12'h050, d, resp, to);
        tests++;
        if (to !== 1'b0 || d !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL rst_no_write: got %h want deadbeef", d);
        end
        axi_write(12'h030, 32'h12345678, 4'hF, resp, to);
        tests++;
        if (to !== 1'b0 || resp !== 2'b00) begin
            fails++;
            $display("FAIL rst_post_write: got resp=%b timeout=%0d want 00 0", resp, to);
        end
        axi_read(12'h030, d, resp, to);
        tests++;
        if (to !== 1'b0 || d !== 32'h12345678) begin
            fails++;
            $display("FAIL rst_post_read: got %h want 12345678", d);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0;
        rready = 1'b0;
        #1;
        test_reset();
        test_fill_readback();
        test_backpressure();
        test_unaligned();
        test_byte_strobes();
        test_channel_order();
        test_read_first();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_ram.md
# axi_lite_ram

AXI4-Lite slave wrapping a 1024 x 32-bit single-clock RAM. Occupies a 4 KiB byte-addressed window and serves one outstanding write and one outstanding read at a time. In the system bench an AXI VIP master drives it. Data bus is 32 bits; word index is `addr[11:2]`.

## Interface
- DATA_WIDTH, 32, data bus and word width. Only 32 is supported.
- DEPTH, 1024, number of words.
- ADDR_WIDTH, 12, byte-address width, equal to log2(DEPTH*4).
- aclk  in  1  single clock. All logic is on its rising edge.
- aresetn  in  1  reset: synchronous and active-low.
- s_axi_awaddr in ADDR_WIDTH, s_axi_awvalid in 1, s_axi_awready out 1: write address channel.
- s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1: write data channel.
- s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1: write response channel.
- s_axi_araddr in ADDR_WIDTH, s_axi_arvalid in 1, s_axi_arready out 1: read address channel.
- s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1: read data channel.
- The awprot and arprot inputs are accepted and ignored.

## Operation
- **Word index:** `addr[11:2]`. `addr[1:0]` is ignored. No address can fall out of range.
- **Write path:** the AW and W channels are captured independently, in either order or in the same cycle.
  - Each captured channel holds its payload and drops its READY until the B handshake completes.
  - When both AW and W are held, the word is written with per-byte enables from wstrb. Byte k is written iff wstrb[k]=1.
  - BVALID is raised with BRESP=OKAY (2'b00). It stays high until BREADY is seen.
- **Read path:**
  - On the AR handshake, the word is read from RAM.
  - RVALID is raised with RDATA and RRESP=OKAY. Both are held stable until RREADY is seen.
  - ARREADY stays low while RVALID=1.
- **Read/write independence:**
  - The read and write paths operate concurrently.
  - If a read and a write to the same word occur on the same edge, the read returns the old data (read-first).
- **Error responses:** none. Every response is OKAY.
- **Memory contents:** not reset; they are undefined until written. Reset affects control state only.

## Timing
- **Reset values** (aresetn=0 at a rising edge): awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0. Any held AW/W/AR state is discarded.
- **Reset mid-operation:** a pending write that has not yet committed is dropped. Pending B or R responses are cancelled.
- **Write latency:**
  - AW and W handshake on the same edge N: the RAM is written and BVALID=1 after edge N+1.
  - AW and W on different edges: the commit happens on the edge after the later handshake.
  - awready and wready return to 1 on the edge after the B handshake. Sustained throughput is one write per 3 cycles.
- **Read latency:** AR handshake on edge N gives RVALID=1 and valid RDATA after edge N. arready returns to 1 on the edge after the R handshake.
- **Handshake rules:**
  - VALID outputs never depend combinationally on READY inputs.
  - Once asserted, a VALID output and its payload stay stable until the handshake completes.
  - READY outputs are registered.
- **Backpressure:** BREADY=0 or RREADY=0 held indefinitely stalls only that path. No data is lost.

## Structure
- A shared package `axi_lite_pkg` holds:
  - the `axi_resp_t` enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3);
  - the DATA_WIDTH/STRB_WIDTH constants.
- One sub-module, `sp_ram_be`: 1024x32 synchronous RAM with byte write enables and read-first behaviour, with separate read and write ports. It maps to BRAM.
- The top-level contains two small FSMs:
  - write FSM: states IDLE, HAVE_AW, HAVE_W, RESP;
  - read FSM: states IDLE, RESP.

## Test plan
- **Fill and readback:** write addr=4*i, data=i, wstrb=4'hF for i=0..1023, then read all 1024 words. Required: every BRESP and RRESP=OKAY, and RDATA=i at addr 4*i.
- **Byte strobes:** write 0xAABBCCDD to 0x010, then write 0x11223344 with wstrb=4'b0101. Reading 0x010 returns 0xAA22CC44.
- **Channel order:**
  - Present W 3 cycles before AW at 0x020, data 0x5A5A5A5A. Required: wready drops after the W handshake and the commit follows the AW handshake; readback returns 0x5A5A5A5A.
  - Repeat with AW first and a different value; readback returns that value.
- **Backpressure:** hold RREADY=0 for 5 cycles after a read of 0x004 (value 1). Required: RVALID stays 1 with RDATA=1, and ARREADY stays 0 until the R handshake.
- **Unaligned address:** a read at 0x006 returns the word at 0x004.
- **Reset mid-write:**
  - Complete the AW handshake, then assert aresetn=0 for 2 cycles before W.
  - Required: all READYs=1, bvalid=0, and no RAM write occurs.
  - Follow with a write of 0x12345678 to 0x030; readback returns 0x12345678.
